// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter for the FIFO write port. Grant takes 1 cycle.
// While locked the arbiter streams 1 beat per cycle. wfull holds the beat; last or a stall timeout releases the port.
module fifo_wr_arbiter #(
  parameter  int DATA_SIZE   = 8,
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT_CYC = 16,
  localparam int GID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         wclk,
  input  logic                         wrst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wfull,
  output logic                         winc,
  output logic [DATA_SIZE-1:0]         wdata,
  output logic                         grant_active,
  output logic [GID_W-1:0]             grant_id,
  output logic                         timeout_err
);

  localparam int                CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [GID_W-1:0]  GID_MAX  = GID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic [DATA_SIZE-1:0] req_data_arr [NUM_REQ];
  logic                 found;
  logic [GID_W-1:0]     winner;
  logic [GID_W-1:0]     idx;
  logic [GID_W-1:0]     next_gid;
  logic                 g_valid;
  logic                 g_last;
  logic                 accept;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data_arr[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
  end

  assign g_valid  = req_valid[grant_id_q];
  assign g_last   = req_last[grant_id_q];
  assign next_gid = (grant_id_q == GID_MAX) ? '0 : grant_id_q + GID_W'(1);

  // Scan downward so the candidate closest to rr_ptr is the last assignment and wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = GID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (state_q == LOCK && !wrst) begin
      req_ready[grant_id_q] = !wfull;
      accept                = g_valid && !wfull;
    end
  end

  assign winc         = accept;
  assign wdata        = req_data_arr[grant_id_q];
  assign grant_active = (state_q == LOCK);
  assign grant_id     = grant_id_q;
  assign timeout_err  = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    stall_cnt_d   = stall_cnt_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = LOCK;
          grant_id_d  = winner;
          stall_cnt_d = '0;
        end
      end
      LOCK: begin
        if (accept) begin
          stall_cnt_d = '0;
          if (g_last) begin
            state_d  = IDLE;
            rr_ptr_d = next_gid;
          end
        end else if (!g_valid && TIMEOUT_CYC > 0) begin
          // Only requester silence counts; a full FIFO with data pending is not a stall.
          if (stall_cnt_q == CNT_LAST) begin
            state_d       = IDLE;
            rr_ptr_d      = next_gid;
            stall_cnt_d   = '0;
            timeout_err_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
